// File: rtl/wb_trace_serializer.sv
// Serializes the dual-issue writeback pair onto the single-lane debug writeback port.
// Bursts are buffered in a fall-through FIFO, retired instructions are counted and protocol violations are flagged.
module wb_trace_serializer #(
   parameter int DEPTH     = 8,
   parameter bit FILTER_R0 = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wb0_en,
   input  logic [4:0]               wb0_rd,
   input  logic [31:0]              wb0_wdata,
   input  logic [31:0]              wb0_pc,
   input  logic                     wb1_en,
   input  logic [4:0]               wb1_rd,
   input  logic [31:0]              wb1_wdata,
   input  logic [31:0]              wb1_pc,
   output logic                     wb_ready,
   input  logic                     out_ready,
   output logic [31:0]              debug_wb_pc,
   output logic [3:0]               debug_wb_rf_wen,
   output logic [4:0]               debug_wb_rf_wnum,
   output logic [31:0]              debug_wb_rf_wdata,
   output logic [31:0]              inst_cnt,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     err_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   pc_mem   [DEPTH];
   logic [4:0]    rd_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;

   logic          elig0;
   logic          elig1;
   logic          accept;
   logic          violation;
   logic          pop;
   logic [PW-1:0] slot1_ptr;
   logic [CW-1:0] push_cnt;
   logic [CW-1:0] count_next;

   // Ready depends only on registered occupancy so a whole pair always fits.
   assign wb_ready   = (count <= CW'(DEPTH - 2));
   assign fifo_level = count;

   always_comb begin
      elig0     = wb0_en && (!FILTER_R0 || (wb0_rd != 5'd0));
      elig1     = wb1_en && (!FILTER_R0 || (wb1_rd != 5'd0));
      accept    = wb_ready;
      violation = (wb0_en || wb1_en) && !wb_ready;
      pop       = (count != '0) && out_ready;
      slot1_ptr = elig0 ? (wptr + PW'(1)) : wptr;
      push_cnt  = '0;
      if (accept) begin
         push_cnt = CW'(elig0) + CW'(elig1);
      end
      count_next = count + push_cnt - CW'(pop);
   end

   // Control state: pointers, occupancy, retire counter, sticky error.
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         inst_cnt     <= '0;
         err_overflow <= 1'b0;
      end else begin
         wptr  <= wptr + push_cnt[PW-1:0];
         count <= count_next;
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
         if (accept) begin
            inst_cnt <= inst_cnt + 32'(wb0_en) + 32'(wb1_en);
         end
         if (violation) begin
            err_overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge clock) begin
      if (!reset && accept) begin
         if (elig0) begin
            pc_mem[wptr]   <= wb0_pc;
            rd_mem[wptr]   <= wb0_rd;
            data_mem[wptr] <= wb0_wdata;
         end
         if (elig1) begin
            pc_mem[slot1_ptr]   <= wb1_pc;
            rd_mem[slot1_ptr]   <= wb1_rd;
            data_mem[slot1_ptr] <= wb1_wdata;
         end
      end
   end

   always_comb begin
      debug_wb_pc       = '0;
      debug_wb_rf_wen   = 4'h0;
      debug_wb_rf_wnum  = '0;
      debug_wb_rf_wdata = '0;
      if (count != '0) begin
         debug_wb_pc       = pc_mem[rptr];
         debug_wb_rf_wen   = 4'hf;
         debug_wb_rf_wnum  = rd_mem[rptr];
         debug_wb_rf_wdata = data_mem[rptr];
      end
   end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Scoreboard bench for wb_trace_serializer: stimulus pushes expected debug writes,
// a negedge monitor pops and compares every entry the sink consumes.
module tb_wb_trace_serializer;

   logic        clock;
   logic        reset;
   logic        wb0_en;
   logic [4:0]  wb0_rd;
   logic [31:0] wb0_wdata;
   logic [31:0] wb0_pc;
   logic        wb1_en;
   logic [4:0]  wb1_rd;
   logic [31:0] wb1_wdata;
   logic [31:0] wb1_pc;
   logic        wb_ready;
   logic        out_ready;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic [31:0] inst_cnt;
   logic [3:0]  fifo_level;
   logic        err_overflow;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t exp_q[$];
   int     errors = 0;
   int     checks = 0;

   wb_trace_serializer #(.DEPTH(8), .FILTER_R0(1'b1)) dut (
      .clock             (clock),
      .reset             (reset),
      .wb0_en            (wb0_en),
      .wb0_rd            (wb0_rd),
      .wb0_wdata         (wb0_wdata),
      .wb0_pc            (wb0_pc),
      .wb1_en            (wb1_en),
      .wb1_rd            (wb1_rd),
      .wb1_wdata         (wb1_wdata),
      .wb1_pc            (wb1_pc),
      .wb_ready          (wb_ready),
      .out_ready         (out_ready),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .inst_cnt          (inst_cnt),
      .fifo_level        (fifo_level),
      .err_overflow      (err_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clearInputs();
      wb0_en = 1'b0; wb0_rd = '0; wb0_wdata = '0; wb0_pc = '0;
      wb1_en = 1'b0; wb1_rd = '0; wb1_wdata = '0; wb1_pc = '0;
   endtask

   // Drives one writeback pair for one clock edge; accepted entries go to the scoreboard.
   task automatic applyStimulus(input logic e0, input logic [4:0] rd0, input logic [31:0] d0, input logic [31:0] pc0,
                                input logic e1, input logic [4:0] rd1, input logic [31:0] d1, input logic [31:0] pc1,
                                input bit expect_accept);
      wb0_en = e0; wb0_rd = rd0; wb0_wdata = d0; wb0_pc = pc0;
      wb1_en = e1; wb1_rd = rd1; wb1_wdata = d1; wb1_pc = pc1;
      if (expect_accept) begin
         if (e0 && rd0 != 5'd0) exp_q.push_back('{pc: pc0, rd: rd0, data: d0});
         if (e1 && rd1 != 5'd0) exp_q.push_back('{pc: pc1, rd: rd1, data: d1});
      end
      tick();
      clearInputs();
   endtask

   task automatic doReset();
      out_ready = 1'b0;
      clearInputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
      checkOutput("reset_level", 32'(fifo_level), 32'd0);
      checkOutput("reset_wen", 32'(debug_wb_rf_wen), 32'd0);
      checkOutput("reset_inst_cnt", inst_cnt, 32'd0);
      checkOutput("reset_wb_ready", 32'(wb_ready), 32'd1);
      checkOutput("reset_err", 32'(err_overflow), 32'd0);
   endtask

   task automatic waitDrain(input int max_cycles);
      int n = 0;
      while (fifo_level != 4'd0 && n < max_cycles) begin
         tick();
         n++;
      end
      checkOutput("drain_level", 32'(fifo_level), 32'd0);
      checkOutput("drain_queue_empty", exp_q.size(), 32'd0);
   endtask

   // Monitor: compares the head entry on every cycle the sink consumes it.
   always @(negedge clock) begin
      if (!reset) begin
         if (debug_wb_rf_wen == 4'hf) begin
            if (out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL stale_output: actual pc=%h rd=%0d data=%h required=no entry",
                           debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
               end else begin
                  entry_t e;
                  e = exp_q.pop_front();
                  if (debug_wb_pc !== e.pc || debug_wb_rf_wnum !== e.rd || debug_wb_rf_wdata !== e.data) begin
                     errors++;
                     $display("[TB] FAIL debug_entry: actual pc=%h rd=%0d data=%h required pc=%h rd=%0d data=%h",
                              debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata, e.pc, e.rd, e.data);
                  end
               end
            end
         end else begin
            checks++;
            if (debug_wb_rf_wen !== 4'h0 || debug_wb_pc !== '0 || debug_wb_rf_wnum !== '0 || debug_wb_rf_wdata !== '0) begin
               errors++;
               $display("[TB] FAIL idle_outputs: actual wen=%h pc=%h rd=%0d data=%h required all zero",
                        debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
            end
         end
      end
   end

   initial begin
      out_ready = 1'b0;
      clearInputs();
      reset = 1'b1;

      // Pair in order, drains in two cycles.
      $display("[TB] test 1: basic pair");
      doReset();
      out_ready = 1'b1;
      applyStimulus(1'b1, 5'd2, 32'd1, 32'hbfc00000, 1'b1, 5'd3, 32'd2, 32'hbfc00004, 1'b1);
      checkOutput("t1_level_after_push", 32'(fifo_level), 32'd2);
      checkOutput("t1_inst_cnt", inst_cnt, 32'd2);
      checkOutput("t1_head_wnum", 32'(debug_wb_rf_wnum), 32'd2);
      waitDrain(10);

      // rd==0 is filtered but still retired.
      $display("[TB] test 2: r0 filter");
      doReset();
      out_ready = 1'b1;
      applyStimulus(1'b1, 5'd0, 32'h11111111, 32'hbfc00008, 1'b1, 5'd5, 32'hdeadbeef, 32'hbfc0000c, 1'b1);
      checkOutput("t2_level", 32'(fifo_level), 32'd1);
      checkOutput("t2_inst_cnt", inst_cnt, 32'd2);
      waitDrain(10);

      // Fill to DEPTH with the sink stalled, then drain.
      $display("[TB] test 3: fill and drain");
      doReset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 5'(2*k+1), 32'hA000 + 32'(k), 32'h1000 + 32'(8*k),
                       1'b1, 5'(2*k+2), 32'hB000 + 32'(k), 32'h1004 + 32'(8*k), 1'b1);
         if (k == 2) checkOutput("t3_ready_at_6", 32'(wb_ready), 32'd1);
      end
      checkOutput("t3_level_full", 32'(fifo_level), 32'd8);
      checkOutput("t3_ready_full", 32'(wb_ready), 32'd0);
      checkOutput("t3_inst_cnt", inst_cnt, 32'd8);
      out_ready = 1'b1;
      waitDrain(20);
      checkOutput("t3_err", 32'(err_overflow), 32'd0);

      // Writeback presented while not ready sets the sticky error.
      $display("[TB] test 4: overflow violation");
      doReset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 5'(10+2*k), 32'hC000 + 32'(k), 32'h3000 + 32'(8*k),
                       1'b1, 5'(11+2*k), 32'hD000 + 32'(k), 32'h3004 + 32'(8*k), 1'b1);
      end
      applyStimulus(1'b1, 5'd20, 32'hE000, 32'h3018, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
      checkOutput("t4_level7", 32'(fifo_level), 32'd7);
      checkOutput("t4_ready_at_7", 32'(wb_ready), 32'd0);
      applyStimulus(1'b1, 5'd21, 32'hF000, 32'h301c, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      checkOutput("t4_err_set", 32'(err_overflow), 32'd1);
      checkOutput("t4_level_held", 32'(fifo_level), 32'd7);
      checkOutput("t4_inst_held", inst_cnt, 32'd7);
      tick();
      tick();
      checkOutput("t4_err_sticky", 32'(err_overflow), 32'd1);
      out_ready = 1'b1;
      waitDrain(20);
      checkOutput("t4_err_after_drain", 32'(err_overflow), 32'd1);

      // Single-slot stream wraps the pointers with occupancy never above one.
      $display("[TB] test 5: streaming wrap");
      doReset();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0)
            applyStimulus(1'b1, 5'((i % 31) + 1), 32'(i*3 + 7), 32'h2000 + 32'(4*i), 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
         else
            applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'((i % 31) + 1), 32'(i*3 + 7), 32'h2000 + 32'(4*i), 1'b1);
         checkOutput("t5_level_le1", 32'(fifo_level), 32'd1);
      end
      waitDrain(5);
      checkOutput("t5_inst_cnt", inst_cnt, 32'd20);

      // Reset mid-burst discards entries and ignores same-cycle inputs.
      $display("[TB] test 6: reset mid-burst");
      doReset();
      applyStimulus(1'b1, 5'd1, 32'h61, 32'h4000, 1'b1, 5'd2, 32'h62, 32'h4004, 1'b1);
      applyStimulus(1'b1, 5'd3, 32'h63, 32'h4008, 1'b1, 5'd4, 32'h64, 32'h400c, 1'b1);
      applyStimulus(1'b1, 5'd5, 32'h65, 32'h4010, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
      checkOutput("t6_level5", 32'(fifo_level), 32'd5);
      reset = 1'b1;
      wb0_en = 1'b1; wb0_rd = 5'd7; wb0_wdata = 32'h77; wb0_pc = 32'h4014;
      tick();
      reset = 1'b0;
      clearInputs();
      exp_q.delete();
      checkOutput("t6_level0", 32'(fifo_level), 32'd0);
      checkOutput("t6_wen0", 32'(debug_wb_rf_wen), 32'd0);
      checkOutput("t6_inst0", inst_cnt, 32'd0);
      checkOutput("t6_ready1", 32'(wb_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      applyStimulus(1'b1, 5'd8, 32'h88, 32'h5000, 1'b1, 5'd9, 32'h99, 32'h5004, 1'b1);
      waitDrain(10);
      checkOutput("t6_inst_after", inst_cnt, 32'd2);

      out_ready = 1'b0;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
